// File: rtl/fifo_uart_tx_pkg.sv
// fifo_uart_tx_pkg
//   Shared definitions for the FIFO-fed 8N1 UART transmitter.
//   - Default frame payload width (kept common with the byte FIFO),
//     default bit period and bit-period counter width.
//   - Transmitter state encoding.
//   - Small helper used by the top level to decide when the bit-period
//     counter runs.
package fifo_uart_tx_pkg;

  // Payload width shared with the byte FIFO's data_width.
  localparam int default_data_width = 8;
  // 50 MHz system clock / 9600 baud.
  localparam int default_clk_div    = 5208;
  // Bit-period counter width; default_clk_div-1 must fit.
  localparam int default_div_width  = 16;

  // Transmitter states.
  // IDLE, REQ and WAIT form the inter-frame gap.
  // START, DATA and STOP put the frame on the line.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
    STOP  = 3'd5
  } tx_state_t;

  // True while a serial bit period is being timed.
  // The bit-period counter is held at zero in every other state.
  function automatic logic is_frame_state(input tx_state_t s);
    return (s == START) || (s == DATA) || (s == STOP);
  endfunction

endpackage

// File: rtl/fifo_uart_tx_baud_tick.sv
// baud_tick
//   Bit-period timer for the UART transmitter.
//   While run=1 it counts 0..clk_div-1 and wraps to 0.
//   It is held at 0 when run=0 or rst=1.
//   clk_div must be at least 2, so that tick_next and tick fall on
//   different cycles.
// Ports
//   clk_actual  in   system clock, posedge
//   rst         in   synchronous active-high reset
//   run         in   1 = count, 0 = hold counter at zero
//   tick        out  high on the last count of a bit period
//   tick_next   out  high one cycle before tick; lets the top level register
//                    a pulse that lines up with the last cycle of a bit
module baud_tick #(
  parameter int clk_div   = fifo_uart_tx_pkg::default_clk_div,
  parameter int div_width = fifo_uart_tx_pkg::default_div_width
) (
  input  logic clk_actual,
  input  logic rst,
  input  logic run,
  output logic tick,
  output logic tick_next
);

  localparam logic [div_width-1:0] last_count = div_width'(clk_div - 1);
  localparam logic [div_width-1:0] prev_count = div_width'(clk_div - 2);

  logic [div_width-1:0] count;

  // Bit-period counter: free-runs over one bit period while run is high.
  always_ff @(posedge clk_actual) begin
    if (rst) begin
      count <= '0;
    end else if (!run) begin
      count <= '0;
    end else if (count == last_count) begin
      count <= '0;
    end else begin
      count <= count + div_width'(1);
    end
  end

  assign tick      = run && (count == last_count);
  assign tick_next = run && (count == prev_count);

endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx
//   Read side of the byte FIFO.
//   Whenever the FIFO is non-empty and transmission is enabled, the block
//   pops one byte and sends it as an 8N1 frame, LSB first.
//   A frame is one start bit (0), data_width data bits and one stop bit (1).
//   Each bit lasts clk_div cycles of clk_actual.
//   The FIFO must register data_out on the same edge that samples the read
//   strobe, so the byte is valid during WAIT.
// Ports
//   clk_actual  in   system clock, posedge
//   rst         in   synchronous active-high reset; aborts a frame in flight
//   tx_enable   in   1 = may start new frames; 0 = finish current frame, idle
//   fifo_empty  in   FIFO empty flag, sampled only in IDLE
//   fifo_data   in   FIFO data_out, valid one cycle after the read strobe
//   fifo_read   out  one-cycle read strobe per frame
//   tx          out  serial line, idle high, registered
//   busy        out  high from REQ through the end of STOP
//   frame_done  out  one-cycle pulse on the last cycle of the stop bit
//   byte_count  out  frames completed since reset, modulo 256
module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int data_width = default_data_width,
  parameter int clk_div    = default_clk_div,
  parameter int div_width  = default_div_width
) (
  input  logic                  clk_actual,
  input  logic                  rst,
  input  logic                  tx_enable,
  input  logic                  fifo_empty,
  input  logic [data_width-1:0] fifo_data,
  output logic                  fifo_read,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done,
  output logic [7:0]            byte_count
);

  localparam int idx_width = (data_width > 1) ? $clog2(data_width) : 1;
  localparam logic [idx_width-1:0] last_idx = idx_width'(data_width - 1);

  tx_state_t             state;
  logic [data_width-1:0] shift;
  logic [idx_width-1:0]  bit_idx;
  logic                  run;
  logic                  tick;
  logic                  tick_next;

  assign run = is_frame_state(state);

  baud_tick #(
    .clk_div   (clk_div),
    .div_width (div_width)
  ) u_baud_tick (
    .clk_actual (clk_actual),
    .rst        (rst),
    .run        (run),
    .tick       (tick),
    .tick_next  (tick_next)
  );

  // Transmit FSM with registered line, strobe and status outputs.
  always_ff @(posedge clk_actual) begin
    if (rst) begin
      state      <= IDLE;
      tx         <= 1'b1;
      fifo_read  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      byte_count <= 8'd0;
      shift      <= '0;
      bit_idx    <= '0;
    end else begin
      // Both strobes are single-cycle.
      // They default low and are raised only on the edge that enters the
      // cycle they mark.
      fifo_read  <= 1'b0;
      frame_done <= 1'b0;

      case (state)
        IDLE: begin
          tx <= 1'b1;
          // fifo_empty is trusted only here.
          // Once REQ is entered, the pop has been committed.
          if (tx_enable && !fifo_empty) begin
            state     <= REQ;
            fifo_read <= 1'b1;
            busy      <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        REQ: begin
          // The FIFO pops on this cycle's closing edge.
          // Its data_out becomes valid during WAIT.
          state <= WAIT;
        end

        WAIT: begin
          shift   <= fifo_data;
          bit_idx <= '0;
          tx      <= 1'b0;
          state   <= START;
        end

        START: begin
          if (tick) begin
            tx      <= shift[0];
            bit_idx <= '0;
            state   <= DATA;
          end else begin
            state <= START;
          end
        end

        DATA: begin
          if (tick) begin
            if (bit_idx == last_idx) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              // The next line level is the bit that the shift is about to
              // move into position 0.
              tx      <= shift[1];
              shift   <= shift >> 1;
              bit_idx <= bit_idx + idx_width'(1);
              state   <= DATA;
            end
          end else begin
            state <= DATA;
          end
        end

        STOP: begin
          tx <= 1'b1;
          if (tick_next) begin
            frame_done <= 1'b1;
          end else begin
            frame_done <= 1'b0;
          end
          if (tick) begin
            busy       <= 1'b0;
            byte_count <= byte_count + 8'd1;
            state      <= IDLE;
          end else begin
            state <= STOP;
          end
        end

        default: begin
          // Unreachable encodings recover to a quiet idle line.
          tx    <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench for fifo_uart_tx (clk_div=4, data_width=8).
// A queue-based FIFO feeds the DUT.
// Each frame is compared against the 8N1 waveform built from the byte value:
// start 0, data LSB first, stop 1, each level held 4 cycles.
// Outputs are sampled on the falling clock edge.
module tb_fifo_uart_tx;

  localparam int clk_div = 4;
  localparam int frame_cycles = 10 * clk_div;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_enable = 1'b0;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_data = 8'd0;
  logic       fifo_read;
  logic       tx;
  logic       busy;
  logic       frame_done;
  logic [7:0] byte_count;

  fifo_uart_tx #(.data_width(8), .clk_div(clk_div), .div_width(16)) dut (
    .clk_actual (clk),
    .rst        (rst),
    .tx_enable  (tx_enable),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_read  (fifo_read),
    .tx         (tx),
    .busy       (busy),
    .frame_done (frame_done),
    .byte_count (byte_count)
  );

  always #5 clk = ~clk;

  // FIFO model: pops on read, data_out and the empty flag register on the same edge.
  logic [7:0] fq[$];
  int bad_reads = 0;
  always @(posedge clk) begin
    if (fifo_read === 1'b1) begin
      if (fq.size() > 0) fifo_data <= fq.pop_front();
      else bad_reads++;
    end
    fifo_empty <= (fq.size() == 0);
  end

  // Pulse counters.
  int reads = 0;
  int fd_cnt = 0;
  always @(negedge clk) begin
    if (fifo_read === 1'b1) reads++;
    if (frame_done === 1'b1) fd_cnt++;
  end

  int n_checks = 0;
  int n_fails = 0;
  logic [7:0] exp_count = 8'd0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected line level at cycle i (0-based) of an 8N1 frame of byte b.
  function automatic logic frame_bit(input logic [7:0] b, input int i);
    int slot;
    slot = i / clk_div;
    if (slot == 0) return 1'b0;
    if (slot == 9) return 1'b1;
    return b[slot-1];
  endfunction

  // Waits (bounded) for tx low; gap = negedges spent with the line high.
  task automatic wait_start(input string tag, output int gap);
    gap = 0;
    while (tx !== 1'b0 && gap < 1000) begin
      gap++;
      @(negedge clk);
    end
    chk({tag, "_start_seen"}, {63'd0, tx}, 64'd0);
  endtask

  // Samples a full frame starting at the current negedge (first START cycle),
  // then checks the counter one cycle after the stop bit.
  task automatic sample_frame(input string tag, input logic [7:0] b);
    logic [39:0] got_tx, exp_tx, got_fd, got_busy;
    for (int i = 0; i < frame_cycles; i++) begin
      if (i > 0) @(negedge clk);
      got_tx[i]   = tx;
      got_fd[i]   = frame_done;
      got_busy[i] = busy;
      exp_tx[i]   = frame_bit(b, i);
    end
    chk({tag, "_tx"}, {24'd0, got_tx}, {24'd0, exp_tx});
    chk({tag, "_frame_done"}, {24'd0, got_fd}, {24'd0, 40'h80_0000_0000});
    chk({tag, "_busy"}, {24'd0, got_busy}, {24'd0, 40'hFF_FFFF_FFFF});
    @(negedge clk);
    exp_count = exp_count + 8'd1;
    chk({tag, "_byte_count"}, {56'd0, byte_count}, {56'd0, exp_count});
  endtask

  initial begin
    int gap;
    int r0;
    int f0;
    int bad;
    logic [7:0] b;
    logic [7:0] rq[$];

    // 1: reset and quiet idle with an empty FIFO
    repeat (3) @(negedge clk);
    chk("rst_tx", {63'd0, tx}, 64'd1);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_read", {63'd0, fifo_read}, 64'd0);
    chk("rst_fd", {63'd0, frame_done}, 64'd0);
    chk("rst_count", {56'd0, byte_count}, 64'd0);
    rst = 1'b0;
    tx_enable = 1'b1;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1 || fifo_read !== 1'b0 || busy !== 1'b0 || byte_count !== 8'd0) bad++;
    end
    chk("idle_empty_quiet", bad, 0);

    // 2: single byte 0xA5
    r0 = reads; f0 = fd_cnt;
    fq.push_back(8'hA5);
    wait_start("a5", gap);
    sample_frame("a5", 8'hA5);
    repeat (10) @(negedge clk);
    chk("a5_reads", reads - r0, 1);
    chk("a5_fd", fd_cnt - f0, 1);

    // 3: three bytes back to back
    r0 = reads;
    fq.push_back(8'h00); fq.push_back(8'hFF); fq.push_back(8'h3C);
    wait_start("b2b0", gap);
    sample_frame("b2b0", 8'h00);
    wait_start("b2b1", gap);
    chk("b2b1_gap", gap, 3);
    sample_frame("b2b1", 8'hFF);
    wait_start("b2b2", gap);
    chk("b2b2_gap", gap, 3);
    sample_frame("b2b2", 8'h3C);
    repeat (20) @(negedge clk);
    chk("b2b_reads", reads - r0, 3);
    chk("b2b_idle_busy", {63'd0, busy}, 64'd0);
    chk("b2b_idle_empty", {63'd0, fifo_empty}, 64'd1);

    // 4: reset during data bit 4 of 0x55
    r0 = reads;
    fq.push_back(8'h55);
    wait_start("abort", gap);
    repeat (5 * clk_div + 1) @(negedge clk);
    chk("abort_bit4", {63'd0, tx}, {63'd0, frame_bit(8'h55, 5 * clk_div + 1)});
    rst = 1'b1;
    fq.push_back(8'h96);
    @(negedge clk);
    exp_count = 8'd0;
    chk("abort_tx", {63'd0, tx}, 64'd1);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_count", {56'd0, byte_count}, {56'd0, exp_count});
    rst = 1'b0;
    wait_start("after_abort", gap);
    sample_frame("after_abort", 8'h96);
    chk("abort_reads", reads - r0, 2);

    // 5: tx_enable dropped during START
    r0 = reads;
    fq.push_back(8'h11); fq.push_back(8'hC7); fq.push_back(8'h6E);
    wait_start("dis", gap);
    tx_enable = 1'b0;
    sample_frame("dis", 8'h11);
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    chk("dis_hold_idle", bad, 0);
    chk("dis_reads", reads - r0, 1);
    tx_enable = 1'b1;
    wait_start("ren0", gap);
    sample_frame("ren0", 8'hC7);
    wait_start("ren1", gap);
    chk("ren1_gap", gap, 3);
    sample_frame("ren1", 8'h6E);
    chk("ren_reads", reads - r0, 3);

    // 6: 256 random frames, byte_count wraps
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_count = 8'd0;
    f0 = fd_cnt;
    for (int k = 0; k < 256; k++) begin
      b = 8'($urandom_range(0, 255));
      rq.push_back(b);
      fq.push_back(b);
    end
    for (int k = 0; k < 256; k++) begin
      b = rq.pop_front();
      wait_start("wrap", gap);
      if (k > 0) chk("wrap_gap", gap, 3);
      sample_frame("wrap", b);
    end
    chk("wrap_count_zero", {56'd0, byte_count}, 64'd0);
    chk("wrap_fd_total", fd_cnt - f0, 256);
    repeat (20) @(negedge clk);
    chk("no_empty_reads", bad_reads, 0);
    chk("final_idle", {63'd0, tx}, 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
